pipelined_barrel_shifter: RTL and testbench



---
 rtl/barrel_shifter_pkg.sv | 55 +++++
 rtl/barrel_shift_stage.sv | 86 ++++++++
 rtl/pipelined_barrel_shifter.sv | 77 +++++++
 tb/tb_pipelined_barrel_shifter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shifter_pkg
// Description : Shared types and helpers for the pipelined barrel shifter.
//               Rotate fill is compiled only when BARREL_SHIFTER_ROTATE_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package barrel_shifter_pkg;

    typedef enum logic [1:0] {
        MODE_LSR = 2'd0,
        MODE_LSL = 2'd1,
        MODE_ASR = 2'd2,
        MODE_ROR = 2'd3
    } shift_mode_t;

    // Widest operand the reverse helper supports.
    localparam int MAX_W = 256;

    // Reverse the low w bits of d; the caller narrows the result to w bits.
    function automatic logic [MAX_W-1:0] bit_reverse(
        input logic [MAX_W-1:0] d,
        input int unsigned      w
    );
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            r[i] = d[MAX_W-1-i];
        end
        return r >> (MAX_W - w);
    endfunction

    function automatic logic fill_bit(
        input shift_mode_t mode,
        input logic        sign,
        input logic        wrap
    );
        logic f;
        f = 1'b0;
        case (mode)
            MODE_ASR: f = sign;
`ifdef BARREL_SHIFTER_ROTATE_EN
            MODE_ROR: f = wrap;
`else
            // Without rotate support mode 3 degrades to a zero-filled LSR.
            MODE_ROR: f = 1'b0 & wrap;
`endif
            default:  f = 1'b0;
        endcase
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/barrel_shift_stage.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shift_stage
// Description : One pipelined right-shift level of distance STEP with fill
//               selection and valid/advance logic. Rotate fill depends on
//               BARREL_SHIFTER_ROTATE_EN (see barrel_shifter_pkg).
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_shift_stage
    import barrel_shifter_pkg::*;
#(
    parameter  int WIDTH        = 8,
    parameter  int STEP         = 1,
    parameter  int SHAMT_BIT    = 0,
    parameter  bit EXIT_REVERSE = 1'b0,
    localparam int SHW          = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   shamt_i,
    input  shift_mode_t      mode_i,
    input  logic             sign_i,
    input  logic             next_load_i,
    output logic             load_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [SHW-1:0]   shamt_o,
    output shift_mode_t      mode_o,
    output logic             sign_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   shamt_q;
    shift_mode_t      mode_q;
    logic             sign_q;

    logic [STEP-1:0]  w_fill;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] data_d;

    for (genvar j = 0; j < STEP; j++) begin : g_fill
        assign w_fill[j] = fill_bit(mode_i, sign_i, data_i[j]);
    end

    assign w_shifted = shamt_i[SHAMT_BIT] ? {w_fill, data_i[WIDTH-1:STEP]} : data_i;

    // The final level undoes the entry reversal so the output stays registered.
    if (EXIT_REVERSE) begin : g_exit_reverse
        assign data_d = (mode_i == MODE_LSL)
                      ? WIDTH'(bit_reverse(MAX_W'(w_shifted), WIDTH))
                      : w_shifted;
    end else begin : g_no_reverse
        assign data_d = w_shifted;
    end

    assign load_o = !valid_q || next_load_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            mode_q  <= MODE_LSR;
            sign_q  <= 1'b0;
        end else if (load_o) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q  <= data_d;
                shamt_q <= shamt_i;
                mode_q  <= mode_i;
                sign_q  <= sign_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign mode_o  = mode_q;
    assign sign_o  = sign_q;

endmodule
`default_nettype wire

// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_barrel_shifter
// Description : Fully pipelined LSR/LSL/ASR/ROR barrel shifter, one register
//               level per shift-amount bit, valid/ready on both sides.
//               Optional rotate: define BARREL_SHIFTER_ROTATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter
    import barrel_shifter_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             w_valid [0:SHW];
    logic [WIDTH-1:0] w_data  [0:SHW];
    logic [SHW-1:0]   w_shamt [0:SHW];
    shift_mode_t      w_mode  [0:SHW];
    logic             w_sign  [0:SHW];
    logic             w_load  [0:SHW];
    shift_mode_t      w_in_mode;

    assign w_in_mode  = shift_mode_t'(in_mode);

    // Left shifts reuse the right-shift tree on bit-reversed data.
    assign w_valid[0] = in_valid;
    assign w_data[0]  = (w_in_mode == MODE_LSL)
                      ? WIDTH'(bit_reverse(MAX_W'(in_data), WIDTH))
                      : in_data;
    assign w_shamt[0] = in_shamt;
    assign w_mode[0]  = w_in_mode;
    assign w_sign[0]  = in_data[WIDTH-1];

    assign w_load[SHW] = out_ready;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        barrel_shift_stage #(
            .WIDTH       (WIDTH),
            .STEP        (1 << (SHW - 1 - k)),
            .SHAMT_BIT   (SHW - 1 - k),
            .EXIT_REVERSE(k == SHW - 1)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .valid_i    (w_valid[k]),
            .data_i     (w_data[k]),
            .shamt_i    (w_shamt[k]),
            .mode_i     (w_mode[k]),
            .sign_i     (w_sign[k]),
            .next_load_i(w_load[k+1]),
            .load_o     (w_load[k]),
            .valid_o    (w_valid[k+1]),
            .data_o     (w_data[k+1]),
            .shamt_o    (w_shamt[k+1]),
            .mode_o     (w_mode[k+1]),
            .sign_o     (w_sign[k+1])
        );
    end

    assign in_ready  = w_load[0];
    assign out_valid = w_valid[SHW];
    assign out_data  = w_data[SHW];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_barrel_shifter
// Description : Scoreboard bench for pipelined_barrel_shifter at WIDTH=8.
//               Follows BARREL_SHIFTER_ROTATE_EN for the expected ROR result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_barrel_shifter;

    localparam int WIDTH = 8;
`ifdef BARREL_SHIFTER_ROTATE_EN
    localparam logic [7:0] C_ROR_B4_3 = 8'h96;
`else
    localparam logic [7:0] C_ROR_B4_3 = 8'h16;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [2:0] in_shamt = 3'd0;
    logic [1:0] in_mode = 2'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } item_t;

    item_t exp_q[$];
    item_t obs_q[$];
    int    cyc = 0;
    int    n_pass = 0;
    int    n_total = 0;

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_shamt (in_shamt),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
        logic [7:0] r;
        case (m)
            2'd0: r = d >> s;
            2'd1: r = d << s;
            2'd2: r = 8'($signed(d) >>> s);
`ifdef BARREL_SHIFTER_ROTATE_EN
            default: r = (d >> s) | (d << (4'd8 - {1'b0, s}));
`else
            default: r = d >> s;
`endif
        endcase
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready)
                exp_q.push_back('{data: model(in_data, in_shamt, in_mode), cyc: cyc});
            if (out_valid && out_ready)
                obs_q.push_back('{data: out_data, cyc: cyc});
        end
    end

    task automatic send(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
        bit acc;
        acc = 1'b0;
        in_data  = d;
        in_shamt = s;
        in_mode  = m;
        in_valid = 1'b1;
        for (int t = 0; t < 40 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_total++;
        if (acc) n_pass++;
        else $display("FAIL send_accept: in_ready never rose for data %02h (required 1)", d);
    endtask

    task automatic wait_obs(input int n);
        for (int t = 0; t < 100 && obs_q.size() < n; t++) @(posedge clk);
        #1;
        n_total++;
        if (obs_q.size() >= n) n_pass++;
        else $display("FAIL wait_obs: got %0d results, required %0d", obs_q.size(), n);
    endtask

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid);
        else n_pass++;
        n_total++;
        if (out_data !== 8'h00) $display("FAIL reset_out_data: got %02h required 00", out_data);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_modes();
        logic [7:0] want [4];
        want[0] = 8'h16; want[1] = 8'hA0; want[2] = 8'hF6; want[3] = C_ROR_B4_3;
        out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            clear_queues();
            send(8'hB4, 3'd3, 2'(m));
            wait_obs(1);
            if (obs_q.size() > 0 && exp_q.size() > 0) begin
                item_t e, o;
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                n_total++;
                if (o.data !== want[m]) $display("FAIL mode%0d_data: got %02h required %02h", m, o.data, want[m]);
                else n_pass++;
                n_total++;
                if (o.cyc - e.cyc !== 3) $display("FAIL mode%0d_latency: got %0d required 3", m, o.cyc - e.cyc);
                else n_pass++;
            end
        end
    endtask

    task automatic test_stream();
        int first;
        out_ready = 1'b1;
        clear_queues();
        for (int i = 0; i < 8; i++) send(8'h01, 3'(i), 2'd1);
        wait_obs(8);
        first = (obs_q.size() > 0) ? obs_q[0].cyc : 0;
        for (int i = 0; i < 8 && obs_q.size() > 0; i++) begin
            item_t o;
            logic [7:0] w;
            o = obs_q.pop_front();
            w = 8'h01 << i;
            n_total++;
            if (o.data !== w) $display("FAIL stream_data[%0d]: got %02h required %02h", i, o.data, w);
            else n_pass++;
            n_total++;
            if (o.cyc !== first + i) $display("FAIL stream_bubble[%0d]: got cycle %0d required %0d", i, o.cyc, first + i);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [7:0] hold;
        out_ready = 1'b0;
        clear_queues();
        send(8'hB4, 3'd1, 2'd0);
        send(8'hB4, 3'd2, 2'd2);
        send(8'h0F, 3'd4, 2'd1);
        in_data = 8'h81; in_shamt = 3'd1; in_mode = 2'd3; in_valid = 1'b1;
        @(negedge clk);
        hold = out_data;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL stall_in_ready_full: got %b required 0", in_ready);
        else n_pass++;
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A)
            $display("FAIL stall_head: got valid %b data %02h required 1/5a", out_valid, out_data);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if (out_data !== hold || in_ready !== 1'b0)
                $display("FAIL stall_hold[%0d]: got data %02h ready %b required %02h/0", i, out_data, in_ready, hold);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL stall_release_accept: got %b required 1", in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_obs(4);
        n_total++;
        if (exp_q.size() !== 4) $display("FAIL stall_accept_count: got %0d required 4", exp_q.size());
        else n_pass++;
        for (int i = 0; i < 4 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            item_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o.data !== e.data) $display("FAIL stall_order[%0d]: got %02h required %02h", i, o.data, e.data);
            else n_pass++;
        end
    endtask

    task automatic test_zero_shift_and_asr();
        logic [7:0] want [5];
        want[0] = 8'h5A; want[1] = 8'h5A; want[2] = 8'h5A; want[3] = 8'h5A; want[4] = 8'hFF;
        out_ready = 1'b1;
        clear_queues();
        for (int m = 0; m < 4; m++) send(8'h5A, 3'd0, 2'(m));
        send(8'h80, 3'd7, 2'd2);
        wait_obs(5);
        for (int i = 0; i < 5 && obs_q.size() > 0; i++) begin
            item_t o;
            o = obs_q.pop_front();
            n_total++;
            if (o.data !== want[i]) $display("FAIL zero_asr[%0d]: got %02h required %02h", i, o.data, want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        clear_queues();
        send(8'h33, 3'd2, 2'd0);
        send(8'h44, 3'd1, 2'd1);
        @(posedge clk);
        #3;
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL midflight_pre: got out_valid %b required 1", out_valid);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_data !== 8'h00)
            $display("FAIL midflight_async: got valid %b data %02h required 0/00", out_valid, out_data);
        else n_pass++;
        repeat (2) @(posedge clk);
        clear_queues();
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_total++;
        if (obs_q.size() !== 0 || out_valid !== 1'b0)
            $display("FAIL midflight_stale: got %0d results valid %b required 0/0", obs_q.size(), out_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_modes();
        test_stream();
        test_back_to_back_stall();
        test_zero_shift_and_asr();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
